// File: rtl/peripheral_ahb3_pkg.sv
// AHB3-Lite encodings used by the BIU-to-AHB bridge.
package peripheral_ahb3_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int HPROT_DATA       = 0;
  localparam int HPROT_PRIVILEGED = 1;
  localparam int HPROT_BUFFERABLE = 2;
  localparam int HPROT_CACHEABLE  = 3;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_ERR2   = 2'd1,
    ST_CANCEL = 2'd2
  } bridge_state_e;
endpackage

// File: rtl/peripheral_biu_pkg.sv
// BIU request-side encodings shared by the core's bus interface and its bridges.
package peripheral_biu_pkg;
  localparam logic [2:0] BYTE   = 3'b000;
  localparam logic [2:0] HWORD  = 3'b001;
  localparam logic [2:0] WORD   = 3'b010;
  localparam logic [2:0] DWORD  = 3'b011;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] WRAP4  = 3'b010;
  localparam logic [2:0] INCR4  = 3'b011;

  localparam logic [1:0] PRV_U  = 2'b00;
endpackage

// File: rtl/riscv_biu_ahb_bridge.sv
// BIU request responder and AHB3-Lite master: one address phase overlapped with
// one data phase, SINGLE transfers only, in-order ack/err per accepted request.
module riscv_biu_ahb_bridge
  import peripheral_biu_pkg::*;
  import peripheral_ahb3_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,

  input  logic            biu_stb,
  output logic            biu_stb_ack,
  input  logic [PLEN-1:0] biu_adri,
  output logic [PLEN-1:0] biu_adro,
  input  logic [2:0]      biu_size,
  input  logic [2:0]      biu_type,
  input  logic            biu_lock,
  input  logic            biu_we,
  input  logic [XLEN-1:0] biu_di,
  output logic [XLEN-1:0] biu_do,
  output logic            biu_ack,
  output logic            biu_err,
  input  logic            biu_is_cacheable,
  input  logic            biu_is_instruction,
  input  logic [1:0]      biu_prv,

  output logic [PLEN-1:0] HADDR,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic            HMASTLOCK,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  input  logic            HREADY,
  input  logic            HRESP
);

  bridge_state_e   state_q;

  logic            ap_valid_q;
  logic [1:0]      htrans_q;
  logic [PLEN-1:0] haddr_q;
  logic            hwrite_q;
  logic [2:0]      hsize_q;
  logic [3:0]      hprot_q;
  logic            hlock_q;
  logic [XLEN-1:0] ap_di_q;

  logic            dp_valid_q;
  logic [PLEN-1:0] dp_adr_q;
  logic [XLEN-1:0] hwdata_q;

  logic            cancel_valid_q;
  logic [PLEN-1:0] cancel_adr_q;

  logic            ack_q;
  logic            err_q;
  logic [PLEN-1:0] adro_q;
  logic [XLEN-1:0] do_q;

  logic [3:0]      prot_d;
  logic            dp_err_first;
  logic            unused_type;

  // Bursts are never generated, so the requested burst type is irrelevant.
  assign unused_type = ^biu_type;

  assign biu_stb_ack  = biu_stb & (state_q == ST_NORMAL) & (~ap_valid_q | HREADY);
  assign dp_err_first = dp_valid_q & ~HREADY & (HRESP == HRESP_ERROR);

  always_comb begin
    prot_d                   = '0;
    prot_d[HPROT_CACHEABLE]  = biu_is_cacheable;
    prot_d[HPROT_BUFFERABLE] = 1'b0;
    prot_d[HPROT_PRIVILEGED] = (biu_prv != PRV_U);
    prot_d[HPROT_DATA]       = ~biu_is_instruction;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_NORMAL;
      ap_valid_q     <= 1'b0;
      htrans_q       <= HTRANS_IDLE;
      haddr_q        <= '0;
      hwrite_q       <= 1'b0;
      hsize_q        <= '0;
      hprot_q        <= '0;
      hlock_q        <= 1'b0;
      ap_di_q        <= '0;
      dp_valid_q     <= 1'b0;
      dp_adr_q       <= '0;
      hwdata_q       <= '0;
      cancel_valid_q <= 1'b0;
      cancel_adr_q   <= '0;
      ack_q          <= 1'b0;
      err_q          <= 1'b0;
      adro_q         <= '0;
      do_q           <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_NORMAL: begin
          if (dp_err_first) begin
            // Drop whatever sits in the address phase; it is reported later
            // as an error without ever reaching the bus.
            state_q        <= ST_ERR2;
            htrans_q       <= HTRANS_IDLE;
            ap_valid_q     <= 1'b0;
            cancel_valid_q <= ap_valid_q | biu_stb_ack;
            cancel_adr_q   <= ap_valid_q ? haddr_q : biu_adri;
          end else begin
            if (HREADY) begin
              dp_valid_q <= ap_valid_q;
              dp_adr_q   <= haddr_q;
              hwdata_q   <= ap_di_q;
              if (dp_valid_q) begin
                adro_q <= dp_adr_q;
                if (HRESP == HRESP_OKAY) begin
                  ack_q <= 1'b1;
                  do_q  <= HRDATA;
                end else begin
                  err_q <= 1'b1;
                end
              end
            end
            if (HREADY || !ap_valid_q) begin
              ap_valid_q <= biu_stb_ack;
              htrans_q   <= biu_stb_ack ? HTRANS_NONSEQ : HTRANS_IDLE;
              if (biu_stb_ack) begin
                haddr_q  <= biu_adri;
                hwrite_q <= biu_we;
                hsize_q  <= biu_size;
                hprot_q  <= prot_d;
                hlock_q  <= biu_lock;
                ap_di_q  <= biu_di;
              end
            end
          end
        end
        ST_ERR2: begin
          if (HREADY) begin
            dp_valid_q     <= 1'b0;
            err_q          <= 1'b1;
            adro_q         <= dp_adr_q;
            cancel_valid_q <= 1'b0;
            state_q        <= cancel_valid_q ? ST_CANCEL : ST_NORMAL;
          end
        end
        ST_CANCEL: begin
          err_q   <= 1'b1;
          adro_q  <= cancel_adr_q;
          state_q <= ST_NORMAL;
        end
        default: state_q <= ST_NORMAL;
      endcase
    end
  end

  assign HTRANS    = htrans_q;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = hprot_q;
  assign HMASTLOCK = hlock_q;
  assign HWDATA    = hwdata_q;

  assign biu_ack   = ack_q;
  assign biu_err   = err_q;
  assign biu_adro  = adro_q;
  assign biu_do    = do_q;

endmodule
